series_datapath: RTL and testbench

SERIES_DATAPATH -- requirements
Module: series_datapath

---
 rtl/series_datapath.sv | 139 +++++++++++++
 tb/tb_series_datapath.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/series_datapath.sv
// Datapath for a series-expansion evaluator: x/temp/res/y registers, LUT counter and a
// Q2.14 multiplier. Define SERIES_SAT_EN to make the res accumulator saturate instead of wrap.
module series_datapath #(
  parameter int DW = 16,
  parameter int FB = 14
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] x_in,
  input  logic [DW-1:0] y_in,
  input  logic          init_cnt_lut,
  input  logic          inc_cnt_lut,
  input  logic          ld_xORx2,
  input  logic          sel_x,
  input  logic          sel_x2,
  input  logic          sel_temp_inpM1,
  input  logic          sel_x_inpM1,
  input  logic          sel_lut_inpM2,
  input  logic          sel_x_inpM2,
  input  logic          init_temp_reg,
  input  logic          ld_temp_reg,
  input  logic          ld_y,
  input  logic          init_res_reg,
  input  logic          ld_res_reg,
  input  logic          add_or_sub,
  output logic          comp_res_y,
  output logic          co_cnt_lut,
  output logic [DW-1:0] result
);

  localparam logic [DW-1:0] ONE = DW'(1 << FB);

  // Coefficients 1/((2k+1)(2k+2)) in Q2.14, truncated.
  localparam logic [DW-1:0] LUT [8] = '{
    DW'(8192), DW'(1365), DW'(546), DW'(292),
    DW'(182),  DW'(124),  DW'(90),  DW'(68)
  };

  logic [DW-1:0] xreg_q, xreg_d;
  logic [DW-1:0] temp_q, temp_d;
  logic [DW-1:0] res_q, res_d;
  logic [DW-1:0] yreg_q, yreg_d;
  logic [2:0]    cnt_q, cnt_d;

  logic signed [DW-1:0]   m1, m2;
  logic signed [2*DW-1:0] prod_full;
  logic [DW-1:0]          product;
  logic signed [DW:0]     sum;
  logic [DW-1:0]          acc;
  logic [DW-1:0]          temp_mag;
  logic                   sel_unused;

  // The x-path selects are the default multiplexer legs and carry no extra information.
  assign sel_unused = ^{sel_x_inpM1, sel_x_inpM2, sum[DW],
                        prod_full[FB-1:0], prod_full[2*DW-1:DW+FB]};

  assign m1        = sel_temp_inpM1 ? temp_q : xreg_q;
  assign m2        = sel_lut_inpM2 ? LUT[cnt_q] : xreg_q;
  assign prod_full = m1 * m2;
  assign product   = prod_full[DW+FB-1:FB];

  always_comb begin
    sum = '0;
    if (add_or_sub) begin
      sum = {res_q[DW-1], res_q} + {temp_q[DW-1], temp_q};
    end else begin
      sum = {res_q[DW-1], res_q} - {temp_q[DW-1], temp_q};
    end
`ifdef SERIES_SAT_EN
    // A sign mismatch between the guard bit and the MSB marks signed overflow.
    if (sum[DW] != sum[DW-1]) begin
      acc = sum[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    end else begin
      acc = sum[DW-1:0];
    end
`else
    acc = sum[DW-1:0];
`endif
  end

  always_comb begin
    xreg_d = xreg_q;
    temp_d = temp_q;
    res_d  = res_q;
    yreg_d = yreg_q;
    cnt_d  = cnt_q;

    if (ld_xORx2 && sel_x) begin
      xreg_d = x_in;
    end else if (ld_xORx2 && sel_x2) begin
      xreg_d = product;
    end

    if (init_temp_reg) begin
      temp_d = ONE;
    end else if (ld_temp_reg) begin
      temp_d = product;
    end

    if (init_res_reg) begin
      res_d = ONE;
    end else if (ld_res_reg) begin
      res_d = acc;
    end

    if (ld_y) begin
      yreg_d = y_in;
    end

    if (init_cnt_lut) begin
      cnt_d = 3'd0;
    end else if (inc_cnt_lut) begin
      cnt_d = cnt_q + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      xreg_q <= '0;
      temp_q <= '0;
      res_q  <= '0;
      yreg_q <= '0;
      cnt_q  <= '0;
    end else begin
      xreg_q <= xreg_d;
      temp_q <= temp_d;
      res_q  <= res_d;
      yreg_q <= yreg_d;
      cnt_q  <= cnt_d;
    end
  end

  // Magnitude is taken unsigned so that -2^(DW-1) maps to 2^(DW-1).
  assign temp_mag   = temp_q[DW-1] ? (~temp_q + 1'b1) : temp_q;
  assign comp_res_y = temp_mag > yreg_q;
  assign co_cnt_lut = (cnt_q == 3'd7);
  assign result     = res_q;

endmodule

// File: tb/tb_series_datapath.sv
// Scoreboard bench for series_datapath: a stimulus process drives strobes at the falling
// edge and queues the expected outputs; a monitor checks them just after the rising edge.
module tb_series_datapath;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] x_in, y_in;
  logic        init_cnt_lut, inc_cnt_lut, ld_xORx2, sel_x, sel_x2;
  logic        sel_temp_inpM1, sel_x_inpM1, sel_lut_inpM2, sel_x_inpM2;
  logic        init_temp_reg, ld_temp_reg, ld_y, init_res_reg, ld_res_reg, add_or_sub;
  logic        comp_res_y, co_cnt_lut;
  logic [15:0] result;

  series_datapath #(.DW(16), .FB(14)) dut (
    .clk(clk), .rst(rst), .x_in(x_in), .y_in(y_in),
    .init_cnt_lut(init_cnt_lut), .inc_cnt_lut(inc_cnt_lut),
    .ld_xORx2(ld_xORx2), .sel_x(sel_x), .sel_x2(sel_x2),
    .sel_temp_inpM1(sel_temp_inpM1), .sel_x_inpM1(sel_x_inpM1),
    .sel_lut_inpM2(sel_lut_inpM2), .sel_x_inpM2(sel_x_inpM2),
    .init_temp_reg(init_temp_reg), .ld_temp_reg(ld_temp_reg), .ld_y(ld_y),
    .init_res_reg(init_res_reg), .ld_res_reg(ld_res_reg), .add_or_sub(add_or_sub),
    .comp_res_y(comp_res_y), .co_cnt_lut(co_cnt_lut), .result(result)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic rstn, init_cnt, inc_cnt, ld_x, sel_x, sel_x2, sel_temp_m1, sel_x_m1;
    logic sel_lut_m2, sel_x_m2, init_temp, ld_temp, ld_y, init_res, ld_res, add;
  } ctl_t;

  typedef struct {
    logic [15:0] res;
    logic        co;
    logic        comp;
    int          id;
  } exp_t;

  exp_t sb[$];
  int   compared = 0;
  int   mismatched = 0;
  int   txn_id = 0;

  // Reference state: signed values for x/temp/res, unsigned y, plain integer counter.
  int m_x = 0, m_temp = 0, m_res = 0, m_y = 0, m_cnt = 0;
  int lut_tab [8] = '{8192, 1365, 546, 292, 182, 124, 90, 68};

  function automatic int wrap16(input longint v);
    longint m;
    m = v & 64'hFFFF;
    if (m >= 32768) m = m - 65536;
    return int'(m);
  endfunction

  function automatic ctl_t idle();
    ctl_t c;
    c = '0;
    c.rstn = 1'b1;
    return c;
  endfunction

  task automatic step(input ctl_t c, input logic [15:0] xv, input logic [15:0] yv);
    int m1, m2, prod, s, nx, nt, nr, ny, nc, mag;
    longint p;
    exp_t e;
    @(negedge clk);
    rst = c.rstn; x_in = xv; y_in = yv;
    init_cnt_lut = c.init_cnt; inc_cnt_lut = c.inc_cnt; ld_xORx2 = c.ld_x;
    sel_x = c.sel_x; sel_x2 = c.sel_x2; sel_temp_inpM1 = c.sel_temp_m1;
    sel_x_inpM1 = c.sel_x_m1; sel_lut_inpM2 = c.sel_lut_m2; sel_x_inpM2 = c.sel_x_m2;
    init_temp_reg = c.init_temp; ld_temp_reg = c.ld_temp; ld_y = c.ld_y;
    init_res_reg = c.init_res; ld_res_reg = c.ld_res; add_or_sub = c.add;

    if (!c.rstn) begin
      nx = 0; nt = 0; nr = 0; ny = 0; nc = 0;
    end else begin
      m1 = c.sel_temp_m1 ? m_temp : m_x;
      m2 = c.sel_lut_m2 ? lut_tab[m_cnt] : m_x;
      p = longint'(m1) * longint'(m2);
      prod = wrap16(p >>> 14);
      nx = (c.ld_x && c.sel_x) ? wrap16(longint'(xv)) : (c.ld_x && c.sel_x2) ? prod : m_x;
      nt = c.init_temp ? 16384 : c.ld_temp ? prod : m_temp;
      s = c.add ? m_res + m_temp : m_res - m_temp;
`ifdef SERIES_SAT_EN
      if (s > 32767) s = 32767;
      if (s < -32768) s = -32768;
`endif
      nr = c.init_res ? 16384 : c.ld_res ? wrap16(longint'(s)) : m_res;
      ny = c.ld_y ? int'(yv) : m_y;
      nc = c.init_cnt ? 0 : c.inc_cnt ? (m_cnt + 1) % 8 : m_cnt;
    end
    m_x = nx; m_temp = nt; m_res = nr; m_y = ny; m_cnt = nc;

    mag = (m_temp < 0) ? -m_temp : m_temp;
    e.res = m_res[15:0];
    e.co = (m_cnt == 7);
    e.comp = (mag > m_y);
    e.id = txn_id;
    txn_id++;
    sb.push_back(e);
  endtask

  // Loads temp with v via the x register: temp = 1.0 * x.
  task automatic load_temp(input int v, input logic [15:0] yv, input logic set_y);
    ctl_t c;
    c = idle(); c.ld_x = 1; c.sel_x = 1; c.init_temp = 1; c.ld_y = set_y;
    step(c, v[15:0], yv);
    c = idle(); c.ld_temp = 1; c.sel_temp_m1 = 1; c.sel_x_m2 = 1;
    step(c, 16'd0, 16'd0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        compared++;
        if (result !== e.res) begin
          mismatched++;
          $display("FAIL result txn %0d: got %0d expected %0d", e.id, $signed(result), $signed(e.res));
        end
        compared++;
        if (co_cnt_lut !== e.co) begin
          mismatched++;
          $display("FAIL co_cnt_lut txn %0d: got %0b expected %0b", e.id, co_cnt_lut, e.co);
        end
        compared++;
        if (comp_res_y !== e.comp) begin
          mismatched++;
          $display("FAIL comp_res_y txn %0d: got %0b expected %0b", e.id, comp_res_y, e.comp);
        end
        $display("txn %0d: result=%0d co=%0b comp=%0b", e.id, $signed(result), co_cnt_lut, comp_res_y);
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    ctl_t c;
    {rst, init_cnt_lut, inc_cnt_lut, ld_xORx2, sel_x, sel_x2, sel_temp_inpM1, sel_x_inpM1,
     sel_lut_inpM2, sel_x_inpM2, init_temp_reg, ld_temp_reg, ld_y, init_res_reg,
     ld_res_reg, add_or_sub} = '1;
    rst = 1'b0; x_in = 16'h7FFF; y_in = 16'h7FFF;

    // Reset with every strobe high.
    c = '1; c.rstn = 1'b0;
    step(c, 16'h7FFF, 16'h7FFF);
    step(c, 16'h7FFF, 16'h7FFF);
    step(idle(), 16'd0, 16'd0);

    // x = 8192, then x = x*x = 4096.
    c = idle(); c.ld_x = 1; c.sel_x = 1; step(c, 16'd8192, 16'd0);
    c = idle(); c.ld_x = 1; c.sel_x2 = 1; c.sel_x_m1 = 1; c.sel_x_m2 = 1; step(c, 16'd0, 16'd0);
    c = idle(); c.init_temp = 1; c.init_res = 1; c.init_cnt = 1; c.ld_y = 1; step(c, 16'd0, 16'd100);
    c = idle(); c.ld_temp = 1; c.sel_temp_m1 = 1; c.sel_x_m2 = 1; step(c, 16'd0, 16'd0);
    c = idle(); c.ld_temp = 1; c.sel_temp_m1 = 1; c.sel_lut_m2 = 1; step(c, 16'd0, 16'd0);
    c = idle(); c.ld_res = 1; c.add = 0; step(c, 16'd0, 16'd0);

    // Counter wrap and init-over-increment priority.
    c = idle(); c.init_cnt = 1; step(c, 16'd0, 16'd0);
    c = idle(); c.inc_cnt = 1;
    for (int i = 0; i < 8; i++) step(c, 16'd0, 16'd0);
    for (int i = 0; i < 3; i++) step(c, 16'd0, 16'd0);
    c = idle(); c.init_cnt = 1; c.inc_cnt = 1; step(c, 16'd0, 16'd0);

    // Threshold compare: negative temp, then the most negative value.
    load_temp(-50, 16'd0, 1'b0);
    load_temp(-32768, 16'd32767, 1'b1);
    load_temp(-32768, 16'd32768, 1'b1);

    // Accumulator overflow: 32000 + 2000, then 32767 negative-side subtract.
    load_temp(15616, 16'd0, 1'b0);
    c = idle(); c.init_res = 1; step(c, 16'd0, 16'd0);
    c = idle(); c.ld_res = 1; c.add = 1; step(c, 16'd0, 16'd0);
    load_temp(2000, 16'd0, 1'b0);
    c = idle(); c.ld_res = 1; c.add = 1; step(c, 16'd0, 16'd0);
    load_temp(32767, 16'd0, 1'b0);
    c = idle(); c.init_res = 1; step(c, 16'd0, 16'd0);
    c = idle(); c.ld_res = 1; c.add = 0; step(c, 16'd0, 16'd0);
    step(c, 16'd0, 16'd0);

    // Reset in the middle of activity.
    c = '1; c.rstn = 1'b0; step(c, 16'h1234, 16'h0010);

    for (int i = 0; i < 600; i++) begin
      logic [15:0] xv, yv;
      c = ctl_t'($urandom);
      c.rstn = ($urandom_range(0, 39) != 0);
      if ($urandom_range(0, 3) != 0) begin
        c.init_temp = 0; c.init_res = 0;
      end
      xv = 16'($urandom);
      yv = ($urandom_range(0, 1) != 0) ? 16'($urandom) : 16'($urandom_range(0, 4096));
      step(c, xv, yv);
    end

    repeat (3) @(posedge clk);
    #2;
    compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL scoreboard drain: %0d left, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
